// File: rtl/md5_fsm.sv
// md5_fsm: iterative MD5 compression engine, one step per accepted word.
// Words arrive already in MD5 schedule order; after step 63 a single FINAL
// cycle folds the working registers into the chaining value and publishes
// the digest. Blocks chain until reset restores the IV.
module md5_fsm (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic [0:31]  msg,
    output logic [0:127] hash_o
);

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    typedef enum logic {
        S_RUN,
        S_FINAL
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_step_en;
    logic        w_final;

    logic [5:0]  r_cnt;
    logic [31:0] r_a, r_b, r_c, r_d;
    logic [31:0] r_ha, r_hb, r_hc, r_hd;

    logic [1:0]  w_round;
    logic [31:0] w_m;
    logic [31:0] w_f;
    logic [31:0] w_k;
    logic [4:0]  w_s;
    logic [31:0] w_t;
    logic [31:0] w_rot;
    logic [31:0] w_na, w_nb, w_nc, w_nd;

    // Reverse byte order of a 32-bit lane (stream order <-> little-endian)
    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Per-step additive constant K[i] = floor(|sin(i+1)| * 2^32)
    function automatic logic [31:0] k_const(input logic [5:0] i);
        logic [31:0] k;
        k = '0;
        case (i)
            6'd0:  k = 32'hd76aa478;  6'd1:  k = 32'he8c7b756;
            6'd2:  k = 32'h242070db;  6'd3:  k = 32'hc1bdceee;
            6'd4:  k = 32'hf57c0faf;  6'd5:  k = 32'h4787c62a;
            6'd6:  k = 32'ha8304613;  6'd7:  k = 32'hfd469501;
            6'd8:  k = 32'h698098d8;  6'd9:  k = 32'h8b44f7af;
            6'd10: k = 32'hffff5bb1;  6'd11: k = 32'h895cd7be;
            6'd12: k = 32'h6b901122;  6'd13: k = 32'hfd987193;
            6'd14: k = 32'ha679438e;  6'd15: k = 32'h49b40821;
            6'd16: k = 32'hf61e2562;  6'd17: k = 32'hc040b340;
            6'd18: k = 32'h265e5a51;  6'd19: k = 32'he9b6c7aa;
            6'd20: k = 32'hd62f105d;  6'd21: k = 32'h02441453;
            6'd22: k = 32'hd8a1e681;  6'd23: k = 32'he7d3fbc8;
            6'd24: k = 32'h21e1cde6;  6'd25: k = 32'hc33707d6;
            6'd26: k = 32'hf4d50d87;  6'd27: k = 32'h455a14ed;
            6'd28: k = 32'ha9e3e905;  6'd29: k = 32'hfcefa3f8;
            6'd30: k = 32'h676f02d9;  6'd31: k = 32'h8d2a4c8a;
            6'd32: k = 32'hfffa3942;  6'd33: k = 32'h8771f681;
            6'd34: k = 32'h6d9d6122;  6'd35: k = 32'hfde5380c;
            6'd36: k = 32'ha4beea44;  6'd37: k = 32'h4bdecfa9;
            6'd38: k = 32'hf6bb4b60;  6'd39: k = 32'hbebfbc70;
            6'd40: k = 32'h289b7ec6;  6'd41: k = 32'heaa127fa;
            6'd42: k = 32'hd4ef3085;  6'd43: k = 32'h04881d05;
            6'd44: k = 32'hd9d4d039;  6'd45: k = 32'he6db99e5;
            6'd46: k = 32'h1fa27cf8;  6'd47: k = 32'hc4ac5665;
            6'd48: k = 32'hf4292244;  6'd49: k = 32'h432aff97;
            6'd50: k = 32'hab9423a7;  6'd51: k = 32'hfc93a039;
            6'd52: k = 32'h655b59c3;  6'd53: k = 32'h8f0ccc92;
            6'd54: k = 32'hffeff47d;  6'd55: k = 32'h85845dd1;
            6'd56: k = 32'h6fa87e4f;  6'd57: k = 32'hfe2ce6e0;
            6'd58: k = 32'ha3014314;  6'd59: k = 32'h4e0811a1;
            6'd60: k = 32'hf7537e82;  6'd61: k = 32'hbd3af235;
            6'd62: k = 32'h2ad7d2bb;  6'd63: k = 32'heb86d391;
            default: k = '0;
        endcase
        return k;
    endfunction

    // Left-rotate amount: four values per round, repeating every 4 steps
    function automatic logic [4:0] s_const(input logic [1:0] r, input logic [1:0] j);
        logic [4:0] s;
        s = '0;
        case ({r, j})
            4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
            4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
            4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
            4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  4'hf: s = 5'd21;
            default: s = '0;
        endcase
        return s;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_RUN;
        else      r_state <= w_state_nxt;
    end

    // Next-state: RUN until step 63 is consumed, then exactly one FINAL cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (rdy && (r_cnt == 6'd63)) w_state_nxt = S_FINAL;
            S_FINAL: w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // FSM outputs: step enable in RUN, chaining/publish strobe in FINAL
    always_comb begin
        w_step_en = 1'b0;
        w_final   = 1'b0;
        case (r_state)
            S_RUN:   w_step_en = rdy;
            S_FINAL: w_final   = 1'b1;
            default: ;
        endcase
    end

    assign w_round = r_cnt[5:4];
    assign w_m     = bswap(msg);
    assign w_k     = k_const(r_cnt);
    assign w_s     = s_const(w_round, r_cnt[1:0]);

    // Round-dependent nonlinear function
    always_comb begin
        w_f = '0;
        case (w_round)
            2'd0: w_f = (r_b & r_c) | (~r_b & r_d);
            2'd1: w_f = (r_b & r_d) | (r_c & ~r_d);
            2'd2: w_f = r_b ^ r_c ^ r_d;
            2'd3: w_f = r_c ^ (r_b | ~r_d);
            default: w_f = '0;
        endcase
    end

    assign w_t   = r_a + w_f + w_k + w_m;
    assign w_rot = (w_t << w_s) | (w_t >> (6'd32 - {1'b0, w_s}));

    assign w_na = r_ha + r_a;
    assign w_nb = r_hb + r_b;
    assign w_nc = r_hc + r_c;
    assign w_nd = r_hd + r_d;

    // Step counter: advances per consumed word, wraps 63 -> 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_cnt <= '0;
        else if (w_step_en) r_cnt <= r_cnt + 6'd1;
    end

    // Working registers: one MD5 step per word, reload from chaining value in FINAL
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a <= IV_A;
            r_b <= IV_B;
            r_c <= IV_C;
            r_d <= IV_D;
        end else if (w_final) begin
            r_a <= w_na;
            r_b <= w_nb;
            r_c <= w_nc;
            r_d <= w_nd;
        end else if (w_step_en) begin
            r_a <= r_d;
            r_b <= r_b + w_rot;
            r_c <= r_b;
            r_d <= r_c;
        end
    end

    // Chaining value and published digest, both updated only in FINAL
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ha   <= IV_A;
            r_hb   <= IV_B;
            r_hc   <= IV_C;
            r_hd   <= IV_D;
            hash_o <= '0;
        end else if (w_final) begin
            r_ha   <= w_na;
            r_hb   <= w_nb;
            r_hc   <= w_nc;
            r_hd   <= w_nd;
            hash_o <= {bswap(w_na), bswap(w_nb), bswap(w_nc), bswap(w_nd)};
        end
    end

endmodule

// File: tb/tb_md5_fsm.sv
// tb_md5_fsm: directed vectors for md5_fsm (reset, empty, "abc", stalls,
// mid-block reset, two-block chaining against a software compression).
module tb_md5_fsm;

    logic         clk;
    logic         rst;
    logic         rdy;
    logic [0:31]  msg;
    logic [0:127] hash_o;

    int n_cmp;
    int n_bad;

    localparam logic [127:0] DIG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] DIG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] IV_NUM    = 128'h67452301_efcdab89_98badcfe_10325476;

    md5_fsm u_dut (
        .clk    (clk),
        .rst    (rst),
        .rdy    (rdy),
        .msg    (msg),
        .hash_o (hash_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %032h expected %032h", tag, got, exp);
        end
    endtask

    // ---------------- software reference ----------------
    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] kval(input int i);
        real    v;
        longint t;
        v = $sin(real'(i + 1));
        if (v < 0.0) v = -v;
        v = $floor(v * 4294967296.0);
        t = longint'(v);
        return t[31:0];
    endfunction

    function automatic int g_idx(input int i);
        case (i / 16)
            0:       return i;
            1:       return (5 * i + 1) % 16;
            2:       return (3 * i + 5) % 16;
            default: return (7 * i) % 16;
        endcase
    endfunction

    // Stream-order word j of a 512-bit block (word 0 in the top bits)
    function automatic logic [31:0] blk_word(input logic [511:0] blk, input int j);
        return blk[511 - 32 * j -: 32];
    endfunction

    function automatic logic [127:0] md5_compress(input logic [127:0] h, input logic [511:0] blk);
        logic [31:0] m [16];
        int          shs [16];
        logic [31:0] a, b, c, d, f, t, tmp;
        int          s;
        shs = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
        for (int j = 0; j < 16; j++) m[j] = bswap(blk_word(blk, j));
        a = h[127:96]; b = h[95:64]; c = h[63:32]; d = h[31:0];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       f = (b & c) | (~b & d);
                1:       f = (d & b) | (~d & c);
                2:       f = b ^ c ^ d;
                default: f = c ^ (b | ~d);
            endcase
            s   = shs[(i / 16) * 4 + (i % 4)];
            t   = a + f + kval(i) + m[g_idx(i)];
            tmp = d;
            d   = c;
            c   = b;
            b   = b + ((t << s) | (t >> (32 - s)));
            a   = tmp;
        end
        return {h[127:96] + a, h[95:64] + b, h[63:32] + c, h[31:0] + d};
    endfunction

    function automatic logic [127:0] to_digest(input logic [127:0] h);
        return {bswap(h[127:96]), bswap(h[95:64]), bswap(h[63:32]), bswap(h[31:0])};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_cycle();
        @(negedge clk);
        rdy = 1'b0;
        msg = $urandom;
    endtask

    task automatic feed(input logic [31:0] w);
        @(negedge clk);
        rdy = 1'b1;
        msg = w;
    endtask

    // Present schedule steps first..last; optional random rdy=0 gaps,
    // always including a gap before step 0 and before step 63.
    task automatic send_steps(input logic [511:0] blk, input int first, input int last, input bit stall);
        for (int i = first; i <= last; i++) begin
            if (stall && (i == 0 || i == 63 || $urandom_range(0, 3) == 0))
                repeat ($urandom_range(1, 3)) idle_cycle();
            feed(blk_word(blk, g_idx(i)));
        end
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        @(negedge clk);
        rdy = 1'b0;
        #2 rst = 1'b0;
        #1 check("reset_async", hash_o, '0);
        #4 rst = 1'b1;
        @(negedge clk);
        check("reset_release", hash_o, '0);
    endtask

    // After the last word: digest must hold for one edge, then update
    task automatic finish_block(input string tag, input logic [127:0] prev, input logic [127:0] exp);
        @(negedge clk);
        check({tag, "_hold"}, hash_o, prev);
        rdy = 1'b0;
        @(negedge clk);
        check(tag, hash_o, exp);
    endtask

    logic [511:0] blk_empty;
    logic [511:0] blk_abc;
    logic [127:0] h1_num;
    logic [127:0] dig2;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        rdy   = 1'b0;
        msg   = '0;

        blk_empty = '0;
        blk_empty[511 -: 32] = 32'h80000000;
        blk_abc   = '0;
        blk_abc[511 -: 32]            = 32'h61626380;
        blk_abc[511 - 32 * 14 -: 32]  = 32'h18000000;

        #12 check("reset_initial", hash_o, '0);
        rst = 1'b1;

        // Empty message from IV
        send_steps(blk_empty, 0, 63, 1'b0);
        finish_block("empty", '0, DIG_EMPTY);

        // "abc" from IV
        do_reset();
        send_steps(blk_abc, 0, 63, 1'b0);
        finish_block("abc", '0, DIG_ABC);

        // Empty message with random stalls
        do_reset();
        send_steps(blk_empty, 0, 63, 1'b1);
        finish_block("stall", '0, DIG_EMPTY);

        // Reset mid-block: 30 words, async reset, then a fresh full block
        send_steps(blk_empty, 0, 29, 1'b0);
        @(negedge clk);
        check("midblk_hold", hash_o, DIG_EMPTY);
        do_reset();
        send_steps(blk_empty, 0, 63, 1'b0);
        finish_block("midblk_empty", '0, DIG_EMPTY);

        // Chaining: empty block then "abc" block, rdy held through FINAL
        do_reset();
        h1_num = md5_compress(IV_NUM, blk_empty);
        dig2   = to_digest(md5_compress(h1_num, blk_abc));
        send_steps(blk_empty, 0, 63, 1'b0);
        @(negedge clk);
        check("chain1_hold", hash_o, '0);
        rdy = 1'b1;
        msg = blk_word(blk_abc, g_idx(0));
        @(negedge clk);
        check("chain1", hash_o, DIG_EMPTY);
        send_steps(blk_abc, 1, 63, 1'b0);
        finish_block("chain2", DIG_EMPTY, dig2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
